// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - FIR convolution sequencer over a circular stereo sample queue.
// Fills the queue, then runs one fixed-length read pass per new sample and captures the band sum.
module fir_seq_ctrl #(
  parameter int DEPTH   = 1024,
  parameter int TAPS    = 1021,
  parameter int SEQ_LEN = 1023,
  parameter int AW      = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid,
  input  logic [15:0]   lft_smpl,
  input  logic [15:0]   rght_smpl,
  output logic          wrt_en,
  output logic [AW-1:0] wrt_addr,
  output logic [15:0]   wrt_lft,
  output logic [15:0]   wrt_rght,
  output logic [AW-1:0] rd_addr,
  output logic          sequencing,
  input  logic [15:0]   band_lft,
  input  logic [15:0]   band_rght,
  output logic [15:0]   lft_out,
  output logic [15:0]   rght_out,
  output logic          out_vld,
  output logic          ovr
);

  localparam int FW = $clog2(TAPS + 1);
  localparam int SW = $clog2(SEQ_LEN);
  localparam logic [FW-1:0] TAPS_C   = FW'(TAPS);
  localparam logic [SW-1:0] SEQ_LAST = SW'(SEQ_LEN - 1);
  localparam logic [SW-1:0] RD_LAST  = SW'(TAPS - 1);

  typedef enum logic [2:0] {S_FILL, S_IDLE, S_WRITE, S_SEQ, S_DONE} state_t;

  state_t        state_q;
  logic [AW-1:0] new_ptr_q, old_ptr_q, rd_addr_q, wrt_addr_q;
  logic [AW-1:0] new_ptr_d, old_ptr_d;
  logic [FW-1:0] fill_cnt_q, fill_cnt_d;
  logic [SW-1:0] seq_cnt_q;
  logic          first_q, pend_q, wrt_en_q, sequencing_q, out_vld_q, ovr_q;
  logic [15:0]   pend_lft_q, pend_rght_q, wrt_lft_q, wrt_rght_q, lft_out_q, rght_out_q;
  logic          busy;

  always_comb begin
    new_ptr_d  = new_ptr_q + 1'b1;
    fill_cnt_d = fill_cnt_q + 1'b1;
    // The very first pass starts at entry 0; every later pass slides the window by one.
    old_ptr_d  = first_q ? old_ptr_q : old_ptr_q + 1'b1;
    busy       = (state_q == S_WRITE) || (state_q == S_SEQ) || (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FILL;
      new_ptr_q    <= '0;
      old_ptr_q    <= '0;
      rd_addr_q    <= '0;
      wrt_addr_q   <= '0;
      fill_cnt_q   <= '0;
      seq_cnt_q    <= '0;
      first_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_lft_q   <= '0;
      pend_rght_q  <= '0;
      wrt_en_q     <= 1'b0;
      wrt_lft_q    <= '0;
      wrt_rght_q   <= '0;
      sequencing_q <= 1'b0;
      out_vld_q    <= 1'b0;
      ovr_q        <= 1'b0;
      lft_out_q    <= '0;
      rght_out_q   <= '0;
    end else begin
      wrt_en_q  <= 1'b0;
      out_vld_q <= 1'b0;

      // A sample arriving mid-pass waits in the one-deep pending slot; a second one is lost.
      if (busy && valid) begin
        if (pend_q) begin
          ovr_q <= 1'b1;
        end else begin
          pend_q      <= 1'b1;
          pend_lft_q  <= lft_smpl;
          pend_rght_q <= rght_smpl;
        end
      end

      case (state_q)
        S_FILL: begin
          if (valid) begin
            wrt_en_q   <= 1'b1;
            wrt_addr_q <= new_ptr_q;
            wrt_lft_q  <= lft_smpl;
            wrt_rght_q <= rght_smpl;
            new_ptr_q  <= new_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            if (fill_cnt_d == TAPS_C) begin
              state_q <= S_IDLE;
              first_q <= 1'b1;
            end
          end
        end
        S_IDLE: begin
          if (pend_q || valid) begin
            wrt_en_q   <= 1'b1;
            wrt_addr_q <= new_ptr_q;
            new_ptr_q  <= new_ptr_d;
            state_q    <= S_WRITE;
            if (pend_q) begin
              wrt_lft_q   <= pend_lft_q;
              wrt_rght_q  <= pend_rght_q;
              pend_q      <= valid;
              pend_lft_q  <= lft_smpl;
              pend_rght_q <= rght_smpl;
            end else begin
              wrt_lft_q  <= lft_smpl;
              wrt_rght_q <= rght_smpl;
            end
          end
        end
        S_WRITE: begin
          old_ptr_q    <= old_ptr_d;
          rd_addr_q    <= old_ptr_d;
          first_q      <= 1'b0;
          seq_cnt_q    <= '0;
          sequencing_q <= 1'b1;
          state_q      <= S_SEQ;
        end
        S_SEQ: begin
          if (seq_cnt_q < RD_LAST) begin
            rd_addr_q <= rd_addr_q + 1'b1;
          end
          if (seq_cnt_q == SEQ_LAST) begin
            lft_out_q    <= band_lft;
            rght_out_q   <= band_rght;
            sequencing_q <= 1'b0;
            out_vld_q    <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            seq_cnt_q <= seq_cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_FILL;
        end
      endcase
    end
  end

  assign wrt_en     = wrt_en_q;
  assign wrt_addr   = wrt_addr_q;
  assign wrt_lft    = wrt_lft_q;
  assign wrt_rght   = wrt_rght_q;
  assign rd_addr    = rd_addr_q;
  assign sequencing = sequencing_q;
  assign lft_out    = lft_out_q;
  assign rght_out   = rght_out_q;
  assign out_vld    = out_vld_q;
  assign ovr        = ovr_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - directed self-checking bench for fir_seq_ctrl.
module tb_fir_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [15:0] lft_smpl, rght_smpl;
  logic        wrt_en;
  logic [9:0]  wrt_addr;
  logic [15:0] wrt_lft, wrt_rght;
  logic [9:0]  rd_addr;
  logic        sequencing;
  logic [15:0] band_lft, band_rght;
  logic [15:0] lft_out, rght_out;
  logic        out_vld;
  logic        ovr;

  int checks = 0;
  int passed = 0;

  int          o_gap, o_rise, o_seqlen, o_rderr, o_vld;
  logic        o_wen1, o_wen2, o_wrap;
  logic [9:0]  o_waddr;
  logic [15:0] o_wl, o_wr, o_lo, o_ro;

  fir_seq_ctrl #(.DEPTH(1024), .TAPS(1021), .SEQ_LEN(1023), .AW(10)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .lft_smpl(lft_smpl), .rght_smpl(rght_smpl),
    .wrt_en(wrt_en), .wrt_addr(wrt_addr), .wrt_lft(wrt_lft), .wrt_rght(wrt_rght),
    .rd_addr(rd_addr), .sequencing(sequencing), .band_lft(band_lft), .band_rght(band_rght),
    .lft_out(lft_out), .rght_out(rght_out), .out_vld(out_vld), .ovr(ovr)
  );

  always #5 clk = ~clk;

  // Runs one pass (issuing its valid, or waiting for a pending sample to be served) and records what it saw.
  task automatic do_pass(input bit pend_mode, input logic [15:0] l, input logic [15:0] r,
                         input logic [9:0] start, input logic [15:0] bl, input logic [15:0] br,
                         input int v1_at, input int v2_at);
    int n;
    int k;
    logic [9:0] er;
    o_gap = 0; o_rise = -1; o_seqlen = 0; o_rderr = 0; o_vld = -1; o_wrap = 1'b0;
    o_wen1 = 1'b0; o_wen2 = 1'b1; o_waddr = '0; o_wl = '0; o_wr = '0; o_lo = '0; o_ro = '0;
    if (pend_mode) begin
      while (wrt_en !== 1'b1 && o_gap < 20) begin
        @(negedge clk);
        o_gap++;
      end
    end else begin
      @(negedge clk);
      valid = 1'b1; lft_smpl = l; rght_smpl = r;
      @(negedge clk);
    end
    n = 1;
    while (n < 1100) begin
      valid = (n == v1_at) || (n == v2_at);
      if (n == v1_at) begin lft_smpl = 16'hC001; rght_smpl = 16'hD001; end
      else if (n == v2_at) begin lft_smpl = 16'hC002; rght_smpl = 16'hD002; end
      if (n == 1) begin o_wen1 = wrt_en; o_waddr = wrt_addr; o_wl = wrt_lft; o_wr = wrt_rght; end
      if (n == 2) o_wen2 = wrt_en;
      if (sequencing === 1'b1) begin
        if (o_rise < 0) o_rise = n;
        o_seqlen++;
        k = o_seqlen - 1;
        if (k > 1020) k = 1020;
        er = start + 10'(k);
        if (rd_addr !== er) o_rderr++;
        if (rd_addr === 10'd0 && o_seqlen > 1) o_wrap = 1'b1;
        band_lft  = (o_seqlen == 1023) ? bl : 16'h0;
        band_rght = (o_seqlen == 1023) ? br : 16'h0;
      end else begin
        band_lft = 16'h0; band_rght = 16'h0;
      end
      if (out_vld === 1'b1) begin
        o_vld = n; o_lo = lft_out; o_ro = rght_out;
        break;
      end
      @(negedge clk);
      n++;
    end
    valid = 1'b0; band_lft = 16'h0; band_rght = 16'h0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wrt_en !== 1'b0) $display("FAIL reset_wrt_en got=%0b exp=0", wrt_en); else passed++;
    checks++; if (sequencing !== 1'b0) $display("FAIL reset_sequencing got=%0b exp=0", sequencing); else passed++;
    checks++; if (out_vld !== 1'b0 || ovr !== 1'b0) $display("FAIL reset_flags got vld=%0b ovr=%0b exp=0,0", out_vld, ovr); else passed++;
    checks++; if (rd_addr !== 10'd0) $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); else passed++;
    checks++; if (lft_out !== 16'h0 || rght_out !== 16'h0) $display("FAIL reset_out got=%h/%h exp=0/0", lft_out, rght_out); else passed++;
    checks++; if (wrt_lft !== 16'h0 || wrt_rght !== 16'h0) $display("FAIL reset_wdata got=%h/%h exp=0/0", wrt_lft, wrt_rght); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill;
    int errs = 0;
    int seqs = 0;
    for (int i = 0; i < 1021; i++) begin
      @(negedge clk);
      valid = 1'b1; lft_smpl = 16'(i); rght_smpl = 16'(i) ^ 16'hFFFF;
      @(negedge clk);
      valid = 1'b0;
      if (wrt_en !== 1'b1 || wrt_addr !== 10'(i) || wrt_lft !== 16'(i) || wrt_rght !== (16'(i) ^ 16'hFFFF)) errs++;
      if (sequencing !== 1'b0) seqs++;
      if (i == 1019) begin
        checks++; if (seqs != 0) $display("FAIL fill_1020_no_seq got=%0d exp=0", seqs); else passed++;
      end
    end
    repeat (20) begin
      @(negedge clk);
      if (sequencing !== 1'b0 || wrt_en !== 1'b0) seqs++;
    end
    checks++; if (errs != 0) $display("FAIL fill_writes bad=%0d exp=0", errs); else passed++;
    checks++; if (seqs != 0) $display("FAIL fill_1021_no_seq got=%0d exp=0", seqs); else passed++;
  endtask

  task automatic test_first_pass;
    do_pass(1'b0, 16'h1111, 16'h2222, 10'd0, 16'h1234, 16'hFEDC, -1, -1);
    checks++; if (o_wen1 !== 1'b1 || o_wen2 !== 1'b0) $display("FAIL p1_wrt_en got=%0b,%0b exp=1,0", o_wen1, o_wen2); else passed++;
    checks++; if (o_waddr !== 10'd1021) $display("FAIL p1_wrt_addr got=%0d exp=1021", o_waddr); else passed++;
    checks++; if (o_wl !== 16'h1111 || o_wr !== 16'h2222) $display("FAIL p1_wdata got=%h/%h exp=1111/2222", o_wl, o_wr); else passed++;
    checks++; if (o_rise != 2) $display("FAIL p1_seq_rise got=%0d exp=2", o_rise); else passed++;
    checks++; if (o_seqlen != 1023) $display("FAIL p1_seq_len got=%0d exp=1023", o_seqlen); else passed++;
    checks++; if (o_rderr != 0) $display("FAIL p1_rd_addr bad=%0d exp=0", o_rderr); else passed++;
    checks++; if (o_vld != 1025) $display("FAIL p1_latency got=%0d exp=1025", o_vld); else passed++;
    checks++; if (o_lo !== 16'h1234 || o_ro !== 16'hFEDC) $display("FAIL p1_capture got=%h/%h exp=1234/fedc", o_lo, o_ro); else passed++;
    @(negedge clk);
    checks++; if (out_vld !== 1'b0) $display("FAIL p1_vld_pulse got=%0b exp=0", out_vld); else passed++;
    repeat (5) @(negedge clk);
    checks++; if (lft_out !== 16'h1234 || rght_out !== 16'hFEDC) $display("FAIL p1_hold got=%h/%h exp=1234/fedc", lft_out, rght_out); else passed++;
    checks++; if (ovr !== 1'b0 || sequencing !== 1'b0) $display("FAIL p1_idle got ovr=%0b seq=%0b exp=0,0", ovr, sequencing); else passed++;
  endtask

  task automatic test_wrap;
    logic [9:0] ea;
    for (int k = 0; k < 4; k++) begin
      ea = 10'd1022 + 10'(k);
      do_pass(1'b0, 16'h3000 + 16'(k), 16'h3100 + 16'(k), 10'(k + 1), 16'h0100 + 16'(k), 16'h0200 + 16'(k), -1, -1);
      checks++; if (o_waddr !== ea) $display("FAIL wrap_waddr%0d got=%0d exp=%0d", k, o_waddr, ea); else passed++;
      checks++; if (o_rderr != 0 || o_seqlen != 1023) $display("FAIL wrap_rd%0d bad=%0d len=%0d exp=0,1023", k, o_rderr, o_seqlen); else passed++;
      checks++; if (o_vld != 1025 || o_lo !== 16'h0100 + 16'(k)) $display("FAIL wrap_out%0d lat=%0d lo=%h exp=1025,%h", k, o_vld, o_lo, 16'h0100 + 16'(k)); else passed++;
    end
    checks++; if (o_wrap !== 1'b1) $display("FAIL wrap_rd_addr got=%0b exp=1", o_wrap); else passed++;
  endtask

  task automatic test_overrun_single;
    do_pass(1'b0, 16'h4000, 16'h4001, 10'd5, 16'h0A0A, 16'h0B0B, 500, -1);
    checks++; if (o_waddr !== 10'd2 || o_vld != 1025) $display("FAIL ovs_pass got addr=%0d lat=%0d exp=2,1025", o_waddr, o_vld); else passed++;
    do_pass(1'b1, 16'h0, 16'h0, 10'd6, 16'h0C0C, 16'h0D0D, -1, -1);
    checks++; if (o_gap != 2) $display("FAIL ovs_served_gap got=%0d exp=2", o_gap); else passed++;
    checks++; if (o_waddr !== 10'd3 || o_wl !== 16'hC001 || o_wr !== 16'hD001) $display("FAIL ovs_pend_write got=%0d %h/%h exp=3 c001/d001", o_waddr, o_wl, o_wr); else passed++;
    checks++; if (o_rderr != 0 || o_vld != 1025 || o_lo !== 16'h0C0C) $display("FAIL ovs_pend_pass bad=%0d lat=%0d lo=%h exp=0,1025,0c0c", o_rderr, o_vld, o_lo); else passed++;
    checks++; if (ovr !== 1'b0) $display("FAIL ovs_ovr got=%0b exp=0", ovr); else passed++;
  endtask

  task automatic test_overrun_double;
    int extra = 0;
    do_pass(1'b0, 16'h4100, 16'h4101, 10'd7, 16'h0E0E, 16'h0F0F, 300, 600);
    checks++; if (ovr !== 1'b1) $display("FAIL ovd_ovr_set got=%0b exp=1", ovr); else passed++;
    checks++; if (o_waddr !== 10'd4 || o_vld != 1025) $display("FAIL ovd_pass got addr=%0d lat=%0d exp=4,1025", o_waddr, o_vld); else passed++;
    do_pass(1'b1, 16'h0, 16'h0, 10'd8, 16'h5A5A, 16'hA5A5, -1, -1);
    checks++; if (o_gap != 2 || o_waddr !== 10'd5) $display("FAIL ovd_served got gap=%0d addr=%0d exp=2,5", o_gap, o_waddr); else passed++;
    checks++; if (o_wl !== 16'hC001 || o_wr !== 16'hD001) $display("FAIL ovd_kept_first got=%h/%h exp=c001/d001", o_wl, o_wr); else passed++;
    checks++; if (o_rderr != 0 || o_lo !== 16'h5A5A || o_ro !== 16'hA5A5) $display("FAIL ovd_pend_pass bad=%0d out=%h/%h exp=0 5a5a/a5a5", o_rderr, o_lo, o_ro); else passed++;
    repeat (30) begin
      @(negedge clk);
      if (sequencing !== 1'b0 || wrt_en !== 1'b0) extra++;
    end
    checks++; if (extra != 0 || ovr !== 1'b1) $display("FAIL ovd_dropped got extra=%0d ovr=%0b exp=0,1", extra, ovr); else passed++;
  endtask

  task automatic test_reset_mid;
    int cnt = 0;
    int guard = 0;
    int bad = 0;
    @(negedge clk);
    valid = 1'b1; lft_smpl = 16'h5555; rght_smpl = 16'h6666;
    @(negedge clk);
    valid = 1'b0;
    while (guard < 1100) begin
      if (sequencing === 1'b1) cnt++;
      if (cnt == 501) break;
      @(negedge clk);
      guard++;
    end
    checks++; if (cnt != 501) $display("FAIL rstm_reach_500 got=%0d exp=501", cnt); else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (sequencing !== 1'b0 || out_vld !== 1'b0) $display("FAIL rstm_abort got seq=%0b vld=%0b exp=0,0", sequencing, out_vld); else passed++;
    checks++; if (rd_addr !== 10'd0 || ovr !== 1'b0 || lft_out !== 16'h0) $display("FAIL rstm_state got rd=%0d ovr=%0b lo=%h exp=0,0,0", rd_addr, ovr, lft_out); else passed++;
    rst_n = 1'b1;
    repeat (1100) begin
      @(negedge clk);
      if (sequencing !== 1'b0 || out_vld !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL rstm_no_pass got=%0d exp=0", bad); else passed++;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid = 1'b1; lft_smpl = 16'h7000 + 16'(i); rght_smpl = 16'h8000;
      @(negedge clk);
      valid = 1'b0;
      if (wrt_en !== 1'b1 || wrt_addr !== 10'(i) || wrt_lft !== 16'h7000 + 16'(i)) bad++;
    end
    repeat (5) begin
      @(negedge clk);
      if (sequencing !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL rstm_refill got=%0d exp=0", bad); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; lft_smpl = '0; rght_smpl = '0; band_lft = '0; band_rght = '0;
    test_reset();
    test_fill();
    test_first_pass();
    test_wrap();
    test_overrun_single();
    test_overrun_double();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
